// File: rtl/qdiv_seq_pkg.sv
// Shared definitions for the sequential signed-magnitude Q-format divider.
package qdiv_seq_pkg;

  localparam int unsigned Q_DEF = 16;
  localparam int unsigned N_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DIVZ = 2'd2,
    DONE = 2'd3
  } state_t;

  // Number of restoring-division steps: (N-1) magnitude bits plus Q fraction bits.
  function automatic int unsigned iter_count(input int unsigned n, input int unsigned q);
    return n + q - 1;
  endfunction

endpackage

// File: rtl/qdiv_seq.sv
// Sequential signed-magnitude fixed-point divider, one quotient bit per clock.
module qdiv_seq
  import qdiv_seq_pkg::*;
#(
  parameter int unsigned Q = Q_DEF,
  parameter int unsigned N = N_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_result,
  output logic         o_ovf,
  output logic         o_div_zero
);

  localparam int unsigned ITER = iter_count(N, Q);
  localparam int unsigned CW   = $clog2(N + Q);

  state_t            state;
  logic [ITER-1:0]   dvd;
  logic [ITER-1:0]   quo;
  logic [N-1:0]      rem;
  logic [N-2:0]      dvsr;
  logic              sign;
  logic [CW-1:0]     step;

  logic [N-1:0]      rem_shift_c;
  logic              ge_c;
  logic [N-1:0]      rem_next_c;
  logic              ovf_c;

  // One restoring step: shift in the next dividend bit, subtract when it fits.
  always_comb begin
    rem_shift_c = {rem[N-2:0], dvd[ITER-1]};
    ge_c        = (rem_shift_c >= {1'b0, dvsr});
    rem_next_c  = ge_c ? (rem_shift_c - {1'b0, dvsr}) : rem_shift_c;
    ovf_c       = |quo[ITER-1:N-1];
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      dvd        <= '0;
      quo        <= '0;
      rem        <= '0;
      dvsr       <= '0;
      sign       <= 1'b0;
      step       <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_result   <= '0;
      o_ovf      <= 1'b0;
      o_div_zero <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            dvd        <= {i_dividend[N-2:0], {Q{1'b0}}};
            quo        <= '0;
            rem        <= '0;
            dvsr       <= i_divisor[N-2:0];
            sign       <= i_dividend[N-1] ^ i_divisor[N-1];
            step       <= '0;
            o_busy     <= 1'b1;
            o_ovf      <= 1'b0;
            o_div_zero <= 1'b0;
            state      <= (i_divisor[N-2:0] == '0) ? DIVZ : RUN;
          end
        end
        RUN: begin
          rem  <= rem_next_c;
          dvd  <= dvd << 1;
          quo  <= {quo[ITER-2:0], ge_c};
          step <= step + CW'(1);
          if (step == CW'(ITER - 1)) begin
            state <= DONE;
          end
        end
        DIVZ: begin
          state <= DONE;
        end
        DONE: begin
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= IDLE;
          if (dvsr == '0) begin
            o_result   <= {sign, {(N-1){1'b1}}};
            o_div_zero <= 1'b1;
          end else if (ovf_c) begin
            o_result <= {sign, {(N-1){1'b1}}};
            o_ovf    <= 1'b1;
          end else begin
            o_result <= {sign, quo[N-2:0]};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qdiv_seq.sv
// Self-checking bench for qdiv_seq: directed cases, handshake/reset cases, random vectors.
module tb_qdiv_seq;

  localparam int unsigned N = 32;
  localparam int unsigned Q = 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [N-1:0]  dividend;
  logic [N-1:0]  divisor;
  logic          busy;
  logic          done;
  logic [N-1:0]  result;
  logic          ovf;
  logic          div_zero;

  int n_vec = 0;
  int n_err = 0;

  qdiv_seq #(.Q(Q), .N(N)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_dividend (dividend),
    .i_divisor  (divisor),
    .o_busy     (busy),
    .o_done     (done),
    .o_result   (result),
    .o_ovf      (ovf),
    .o_div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division of the scaled magnitudes.
  function automatic void ref_div(input logic [N-1:0] a, input logic [N-1:0] b,
                                  output logic [N-1:0] res, output logic r_ovf,
                                  output logic r_dz, output int lat);
    logic [63:0] ma, mb, qf;
    logic        s;
    s     = a[N-1] ^ b[N-1];
    ma    = 64'(a[N-2:0]);
    mb    = 64'(b[N-2:0]);
    r_ovf = 1'b0;
    r_dz  = 1'b0;
    if (mb == 0) begin
      r_dz = 1'b1;
      res  = {s, {(N-1){1'b1}}};
      lat  = 2;
    end else begin
      qf  = (ma << Q) / mb;
      lat = N + Q;
      if ((qf >> (N-1)) != 0) begin
        r_ovf = 1'b1;
        res   = {s, {(N-1){1'b1}}};
      end else begin
        res = {s, qf[N-2:0]};
      end
    end
  endfunction

  // Raise start with operands; call from a negedge.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
  endtask

  // Wait from the accept edge to o_done and check everything; returns at the o_done negedge.
  // poke>0 pulses a spurious start (with junk operands) sampled at that edge of the run.
  task automatic collect(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input int poke);
    logic [N-1:0] e_res;
    logic         e_ovf, e_dz;
    int           e_lat, edges;
    bit           seen;
    ref_div(a, b, e_res, e_ovf, e_dz, e_lat);
    @(posedge clk);
    #1 start = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    check_eq({tag, "_busy"}, 64'(busy), 64'(1));
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 200) begin
      @(posedge clk);
      edges++;
      #1;
      if (poke > 0 && edges == poke - 1) begin
        start    = 1'b1;
        dividend = 32'h0001_0000;
        divisor  = 32'h0000_0001;
      end
      if (poke > 0 && edges == poke) start = 1'b0;
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check_eq({tag, "_lat"}, 64'(edges), 64'(e_lat));
    check_eq({tag, "_res"}, 64'(result), 64'(e_res));
    check_eq({tag, "_flags"}, {62'd0, ovf, div_zero}, {62'd0, e_ovf, e_dz});
    check_eq({tag, "_idle"}, 64'(busy), 64'(0));
  endtask

  task automatic run_one(input string tag, input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    issue(a, b);
    collect(tag, a, b, 0);
  endtask

  initial begin
    logic [N-1:0] ra, rb, hold;
    bit           got_done;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_outs", {59'd0, busy, done, ovf, div_zero, |result}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_one("t1_6div2",    32'h0006_0000, 32'h0002_0000);
    run_one("t2_neg",      32'h8001_8000, 32'h0000_8000);
    run_one("t3_third",    32'h0001_0000, 32'h0003_0000);
    run_one("t4_ovf",      32'h4000_0000, 32'h0000_0100);
    run_one("t5_divnegz",  32'h0001_0000, 32'h8000_0000);

    // o_done is a single-cycle pulse and the result holds afterwards.
    hold = result;
    @(negedge clk);
    check_eq("done_pulse", 64'(done), 64'(0));
    check_eq("res_hold", 64'(result), 64'(hold));

    // Spurious start in the middle of a run must be ignored.
    @(negedge clk);
    issue(32'h0009_0000, 32'h0003_0000);
    collect("t6_ignore", 32'h0009_0000, 32'h0003_0000, 10);

    // Back-to-back: start raised during the o_done cycle.
    issue(32'h8000_4000, 32'h8002_0000);
    collect("t6_b2b", 32'h8000_4000, 32'h8002_0000, 0);

    // Reset in the middle of a run.
    @(negedge clk);
    issue(32'h0005_0000, 32'h0002_0000);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_eq("rst_mid_outs", {59'd0, busy, done, ovf, div_zero, |result}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    got_done = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (done) got_done = 1'b1;
    end
    check_eq("rst_no_done", 64'(got_done), 64'(0));
    run_one("t6_after_rst", 32'h0005_0000, 32'h0002_0000);

    // Random vectors spanning wide magnitude ranges, with occasional zero divisors.
    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = $urandom;
      rb = {rb[N-1], rb[N-2:0] >> $urandom_range(N-2, 0)};
      ra = {ra[N-1], ra[N-2:0] >> $urandom_range(N-2, 0)};
      if ($urandom_range(9, 0) == 0) rb = {rb[N-1], {(N-1){1'b0}}};
      run_one("rand", ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
